// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Shares one 4-bit seven-segment decoder between the four digits of a
// multiplexed display. The controller visits slots 0..3 in turn. For each
// slot it puts that slot's nibble on dec_in and pulls the matching anode
// low. Each slot starts with a short all-dark interval so that the previous
// digit does not ghost into the next one. The digit values are captured once
// per frame, so an update made part way through a frame cannot tear.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active high
//   en          scan enable; while low the display is dark and state idles
//   digits      four nibbles, slot k shows digits[4k+3:4k]
//   digit_en    per-slot lit mask (1 = lit), sampled every cycle
//   dec_in      nibble presented to the shared decoder
//   an          active-low anodes: one-hot-low, or all ones
//   slot        current slot index
//   frame_tick  one-cycle pulse on the final cycle of slot 3
module display_scan_controller #(
    parameter int SCAN_DIV     = 100000,  // cycles per slot, >= 2
    parameter int BLANK_CYCLES = 1000     // dark cycles per slot, < SCAN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    output logic [3:0]  dec_in,
    output logic [3:0]  an,
    output logic [1:0]  slot,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE    = CW'(SCAN_DIV - 2);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit            NO_BLANK   = (BLANK_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    // Every slot begins in this state. When no blanking is configured the
    // dark phase is skipped altogether.
    localparam state_t START = NO_BLANK ? DRIVE : BLANK;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   snap;
    logic [1:0]    next_slot;

    assign next_slot = slot + 2'd1;

    // Anode pattern for a lit slot. A masked-off slot stays dark.
    function automatic logic [3:0] lit(input logic [1:0] s, input logic [3:0] m);
        return ~((4'b0001 << s) & m);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            slot       <= 2'd0;
            snap       <= 16'h0;
            dec_in     <= 4'h0;
            an         <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    slot       <= 2'd0;
                    frame_tick <= 1'b0;
                    if (en) begin
                        snap   <= digits;
                        dec_in <= digits[3:0];
                        an     <= NO_BLANK ? lit(2'd0, digit_en) : 4'hF;
                        state  <= START;
                    end else begin
                        dec_in <= 4'h0;
                        an     <= 4'hF;
                    end
                end

                default: begin  // BLANK or DRIVE
                    if (!en) begin
                        // Disable takes priority over a slot boundary.
                        state      <= IDLE;
                        cnt        <= '0;
                        slot       <= 2'd0;
                        dec_in     <= 4'h0;
                        an         <= 4'hF;
                        frame_tick <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        slot       <= next_slot;
                        state      <= START;
                        frame_tick <= 1'b0;
                        an         <= NO_BLANK ? lit(next_slot, digit_en) : 4'hF;
                        if (slot == 2'd3) begin
                            // Frame wrap: take a new snapshot and show the
                            // live slot-0 nibble, because snap only updates
                            // at this same edge.
                            snap   <= digits;
                            dec_in <= digits[3:0];
                        end else begin
                            dec_in <= snap[{next_slot, 2'b00} +: 4];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        // Register the pulse so that it lands on the final
                        // cycle of slot 3.
                        frame_tick <= (slot == 2'd3) && (cnt == CNT_PRE);
                        if (state == DRIVE || cnt == BLANK_LAST) begin
                            state <= DRIVE;
                            an    <= lit(slot, digit_en);
                        end else begin
                            an    <= 4'hF;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller, with SCAN_DIV=8 and
// BLANK_CYCLES=2. A second instance with BLANK_CYCLES=0 checks the
// no-blanking case.
module tb_display_scan_controller;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dec_in, an, dec_in_nb, an_nb;
    logic [1:0]  slot, slot_nb;
    logic        frame_tick, frame_tick_nb;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] fd [4];
    logic [3:0]  fm [4];

    always #5 clk = ~clk;

    display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .digit_en(digit_en),
        .dec_in(dec_in), .an(an), .slot(slot), .frame_tick(frame_tick)
    );

    display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .digit_en(digit_en),
        .dec_in(dec_in_nb), .an(an_nb), .slot(slot_nb), .frame_tick(frame_tick_nb)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " an"}, {12'h0, an}, 16'h000F);
        chk({tag, " dec_in"}, {12'h0, dec_in}, 16'h0000);
        chk({tag, " slot"}, {14'h0, slot}, 16'h0000);
        chk({tag, " frame_tick"}, {15'h0, frame_tick}, 16'h0000);
    endtask

    // Expected outputs for cycle c, where cycle 0 is the first cycle after
    // the enable edge.
    task automatic check_cycle(input bit nb, input int c, input logic [15:0] fdig,
                               input logic [3:0] fmask);
        int s, k, blank;
        logic [3:0] a_e, d_e, a_o, d_o;
        logic [1:0] s_o;
        logic ft_e, ft_o;
        s     = (c / SD) % 4;
        k     = c % SD;
        blank = nb ? 0 : BC;
        a_e   = (k < blank) ? 4'hF : ~((4'b0001 << s) & fmask);
        d_e   = fdig[s*4 +: 4];
        ft_e  = ((c % (4*SD)) == (4*SD - 1));
        a_o   = nb ? an_nb : an;
        d_o   = nb ? dec_in_nb : dec_in;
        s_o   = nb ? slot_nb : slot;
        ft_o  = nb ? frame_tick_nb : frame_tick;
        chk($sformatf("an nb=%0d c=%0d", nb, c), {12'h0, a_o}, {12'h0, a_e});
        chk($sformatf("dec_in nb=%0d c=%0d", nb, c), {12'h0, d_o}, {12'h0, d_e});
        chk($sformatf("slot nb=%0d c=%0d", nb, c), {14'h0, s_o}, 16'(s));
        chk($sformatf("frame_tick nb=%0d c=%0d", nb, c), {15'h0, ft_o}, {15'h0, ft_e});
        chk($sformatf("onehot nb=%0d c=%0d", nb, c), 16'($countones(~a_o) <= 1), 16'h0001);
    endtask

    initial begin
        fd[0] = 16'h4321; fd[1] = 16'hABCD; fd[2] = 16'h4321; fd[3] = 16'h4321;
        fm[0] = 4'hF;     fm[1] = 4'hF;     fm[2] = 4'h5;     fm[3] = 4'h5;

        rst = 1'b1; en = 1'b0; digits = 16'h4321; digit_en = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("reset");

        // Basic scan, tearing, mask and disable, all in one continuous run
        en = 1'b1;
        for (int c = 0; c < 118; c++) begin
            @(posedge clk); #1;
            check_cycle(1'b0, c, fd[c / 32], fm[c / 32]);
            if (c == 10)  digits   = 16'hABCD;  // mid slot 1, frame 0
            if (c == 40)  digits   = 16'h4321;  // mid slot 1, frame 1
            if (c == 63)  digit_en = 4'h5;
            if (c == 117) en       = 1'b0;      // slot 2, cnt 5
        end
        @(posedge clk); #1;
        chk_idle("disable");
        @(posedge clk); #1;
        chk_idle("idle hold");

        // Restart with a fresh snapshot
        digits = 16'h8765; digit_en = 4'hF; en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_cycle(1'b0, c, 16'h8765, 4'hF);
        end

        // Asynchronous reset mid-DRIVE, between edges
        #3 rst = 1'b1;
        #1;
        chk_idle("async reset");
        en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_idle($sformatf("post reset %0d", i));
        end

        // No-blanking instance
        digits = 16'h4321; digit_en = 4'hF; en = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(posedge clk); #1;
            check_cycle(1'b1, c, 16'h4321, 4'hF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
